// File: rtl/uart_tx_arbiter_if.sv
// Request/ack bus plus serial-line outputs of the shared UART transmitter.
// The master side drives the byte producers and the pause control; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic              pause;
    logic [NREQ-1:0]   ack;
    logic              out;
    logic              busy;
    logic [IDW-1:0]    grant;

    modport master (
        output req, din, pause,
        input  ack, out, busy, grant
    );

    modport slave (
        input  req, din, pause,
        output ack, out, busy, grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises one requester byte per frame onto a shared line.
// Frame format: start bit 1, 8 data bits LSB first, stop bit 0, one bit per clock.
module uart_tx_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            out_q, out_d;
    logic            busy_q, busy_d;

    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic [7:0]      win_byte;
    logic            arb;

    // Scan from rr+1 upward with wrap so the last owner is lowest priority.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        win_byte  = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand = IDW'((int'(rr_q) + k) % int'(NREQ));
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!win_found && cand == IDW'(i) && bus.req[i]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_idx == IDW'(i)) begin
                win_byte = bus.din[8*i +: 8];
            end
        end
    end

    assign arb = (state_q == StIdle || state_q == StStop) && !bus.pause && win_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StStop: state_d = arb ? StStart : StIdle;
            StStart:        state_d = StData;
            StData:         if (cnt_q == 3'd7) state_d = StStop;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        ack_d   = '0;
        out_d   = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle, StStop: begin
                if (arb) begin
                    shreg_d = win_byte;
                    rr_d    = win_idx;
                    grant_d = win_idx;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        ack_d[i] = (win_idx == IDW'(i));
                    end
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            StStart: begin
                out_d   = shreg_q[0];
                shreg_d = {1'b0, shreg_q[7:1]};
                cnt_d   = '0;
            end
            StData: begin
                // cnt counts bits 1..7 already sent; at 7 the stop bit (0) goes out.
                if (cnt_q != 3'd7) begin
                    out_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            rr_q    <= IDW'(NREQ - 1);
            grant_q <= '0;
            ack_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.out   = out_q;
    assign bus.busy  = busy_q;
    assign bus.grant = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for reset and a single frame, then directed sequences
// with a scoreboard of {grant, byte} checked by an ack monitor and a serial receiver model.
module tb_uart_tx_arbiter;
    logic clk;
    logic reset;

    uart_tx_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    uart_tx_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       pause;
        logic       out;
        logic [3:0] ack;
        logic       busy;
        logic [1:0] grant;
    } vec_t;

    typedef struct {
        logic [1:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial receiver model standing in for uart_rx.
    int         rx_st;
    int         rx_n;
    logic [7:0] rx_sh;
    exp_t       rx_e;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            rx_st = 0;
            rx_n  = 0;
        end else begin
            case (rx_st)
                0: if (bus.out) begin
                    rx_st = 1;
                    rx_n  = 0;
                end
                1: begin
                    rx_sh = {bus.out, rx_sh[7:1]};
                    rx_n++;
                    if (rx_n == 8) rx_st = 2;
                end
                default: begin
                    check("stop bit", bus.out, 0);
                    check("rx frame expected", (sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        rx_e = sb.pop_front();
                        check("rx byte", rx_sh, rx_e.b);
                    end
                    rx_st = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.ack != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected ack", bus.ack, 0);
            end else begin
                check("ack one-hot", bus.ack, 4'b0001 << sb[0].g);
                check("grant at ack", bus.grant, sb[0].g);
            end
        end
    end

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.ack == 4'b0000 && cyc < 40);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 40);
        check("idle reached", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    vec_t vec [16];
    int   c;

    initial begin
        // Reset for two cycles, then byte AC from requester 2, then pause holding off a request.
        vec[0]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vec[1]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vec[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
        vec[3]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vec[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vec[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vec[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
        vec[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
        vec[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vec[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
        vec[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vec[11] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
        vec[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
        vec[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
        vec[14] = '{1'b0, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2};
        vec[15] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};

        reset     = 1'b1;
        bus.req   = 4'b0000;
        bus.pause = 1'b0;
        bus.din   = {8'h44, 8'hAC, 8'h22, 8'h11};
        sb.push_back('{2'd2, 8'hAC});

        foreach (vec[i]) begin
            reset     = vec[i].rst;
            bus.req   = vec[i].req;
            bus.pause = vec[i].pause;
            @(negedge clk);
            check($sformatf("vec%0d out", i), bus.out, vec[i].out);
            check($sformatf("vec%0d ack", i), bus.ack, vec[i].ack);
            check($sformatf("vec%0d busy", i), bus.busy, vec[i].busy);
            check($sformatf("vec%0d grant", i), bus.grant, vec[i].grant);
        end

        // All four requesting: grants 0,1,2,3,0 back to back.
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
        sb.push_back('{2'd0, 8'h11});
        sb.push_back('{2'd1, 8'h22});
        sb.push_back('{2'd2, 8'h33});
        sb.push_back('{2'd3, 8'h44});
        sb.push_back('{2'd0, 8'h11});
        bus.req = 4'b1111;
        wait_ack(c);
        check("t3 first ack latency", c, 1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(c);
            check("t3 ack spacing", c, 10);
        end
        bus.req = 4'b0000;
        wait_idle();

        // Last grant 1, then 1 and 3 together: 3 wins first, 1 at the next stop.
        bus.din = {8'hC3, 8'h33, 8'h5A, 8'h11};
        sb.push_back('{2'd1, 8'h5A});
        bus.req = 4'b0010;
        wait_ack(c);
        check("t4 setup latency", c, 1);
        bus.req = 4'b0000;
        wait_idle();
        sb.push_back('{2'd3, 8'hC3});
        sb.push_back('{2'd1, 8'h5A});
        bus.req = 4'b1010;
        wait_ack(c);
        check("t4 first latency", c, 1);
        check("t4 first grant", bus.grant, 3);
        wait_ack(c);
        check("t4 second spacing", c, 10);
        check("t4 second grant", bus.grant, 1);
        bus.req = 4'b0000;
        wait_idle();

        // Reset in the fifth cycle of a frame abandons it; a fresh frame follows.
        bus.din[7:0] = 8'h93;
        sb.push_back('{2'd0, 8'h93});
        bus.req = 4'b0001;
        wait_ack(c);
        check("t5 ack latency", c, 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        check("t5 out on reset", bus.out, 0);
        check("t5 busy on reset", bus.busy, 0);
        check("t5 ack on reset", bus.ack, 0);
        @(negedge clk);
        check("t5 out held", bus.out, 0);
        check("t5 no ack", bus.ack, 0);
        reset = 1'b0;
        sb.push_back('{2'd0, 8'h93});
        wait_ack(c);
        check("t5 fresh ack latency", c, 1);
        bus.req = 4'b0000;
        wait_idle();

        // Pause mid-frame: frame completes, pending request waits until pause drops.
        bus.din = {8'hC3, 8'h33, 8'h5A, 8'h11};
        sb.push_back('{2'd1, 8'h5A});
        bus.req = 4'b0010;
        wait_ack(c);
        check("t6 ack latency", c, 1);
        repeat (2) @(negedge clk);
        bus.pause = 1'b1;
        bus.req   = 4'b0001;
        wait_idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t6 paused out", bus.out, 0);
            check("t6 paused ack", bus.ack, 0);
            check("t6 paused busy", bus.busy, 0);
        end
        sb.push_back('{2'd0, 8'h11});
        bus.pause = 1'b0;
        wait_ack(c);
        check("t6 resume latency", c, 1);
        check("t6 start bit", bus.out, 1);
        bus.req = 4'b0000;
        wait_idle();

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
